// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter
// and the downstream truncation mask stage.
package rr_grant_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int unsigned MAX_N = 32;

   function automatic logic [4:0] onehot_to_idx(
      input logic [MAX_N-1:0] v
   );
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) idx |= 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_msb_pick.sv
// Combinational highest-set-bit picker: one-hot of the MSB
// plus an any-bit flag.
module msb_pick #(
   parameter int N = 5
) (
   input  logic [N-1:0] v,
   output logic [N-1:0] onehot,
   output logic         any
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

   assign any = |v;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with valid/ready grant handshake;
// last accepted grant truncates priority to the requesters below it.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter  int N  = 5,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid,
   input  logic          grant_ready,
   output logic [N-1:0]  last_grant
);

   state_e        state;
   state_e        state_nx;
   logic [N-1:0]  grant_nx;
   logic [N-1:0]  last_nx;
   logic [IW-1:0] idx_nx;
   logic [N-1:0]  sel_r;
   logic [N-1:0]  sel_t;
   logic [N-1:0]  mask;
   logic [N-1:0]  masked;
   logic [N-1:0]  pick_m;
   logic [N-1:0]  pick_r;
   logic [N-1:0]  pick;
   logic          any_m;
   logic          any_r;
   logic          accept;

   // IDLE truncates by the last accepted grant, GRANT by the one
   // being accepted now (its own bit already removed from sel_r).
   assign sel_r = (state == IDLE) ? req : (req & ~grant);
   assign sel_t = (state == IDLE) ? last_grant : grant;

   always_comb begin
      mask[0] = sel_t[0];
      for (int i = 1; i < N; i++) begin
         mask[i] = mask[i-1] | sel_t[i];
      end
   end

   assign masked = sel_r & ~mask;

   msb_pick #(.N(N)) u_pick_m (
      .v      (masked),
      .onehot (pick_m),
      .any    (any_m)
   );

   msb_pick #(.N(N)) u_pick_r (
      .v      (sel_r),
      .onehot (pick_r),
      .any    (any_r)
   );

   assign pick        = any_m ? pick_m : pick_r;
   assign grant_valid = (state == GRANT);
   assign accept      = grant_valid & grant_ready;

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      last_nx  = last_grant;
      unique case (state)
         IDLE: begin
            if (any_r) begin
               grant_nx = pick;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               last_nx  = grant;
               grant_nx = any_r ? pick : '0;
               state_nx = any_r ? GRANT : IDLE;
            end
         end
      endcase
      idx_nx = IW'(onehot_to_idx(MAX_N'(grant_nx)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         grant_idx  <= '0;
         last_grant <= '0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         grant_idx  <= idx_nx;
         last_grant <= last_nx;
      end
   end

   a_onehot: assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(grant));

   a_valid: assert property (
      @(posedge clk) disable iff (!rst_n)
      ((grant != '0) == grant_valid));

   a_req_held: assert property (
      @(posedge clk) disable iff (!rst_n)
      grant_valid |-> ((req & grant) == grant));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random
// traffic checked against a descending round-robin model.
module tb_rr_grant_arbiter;

   localparam int N  = 5;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic          grant_ready = 1'b0;
   logic [N-1:0]  grant;
   logic [IW-1:0] grant_idx;
   logic          grant_valid;
   logic [N-1:0]  last_grant;

   int n_chk  = 0;
   int n_fail = 0;

   rr_grant_arbiter #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .grant_ready (grant_ready),
      .last_grant  (last_grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // Descending rotation: first requester strictly below t, else wrap
   // to the highest requester.
   function automatic int sel(input logic [N-1:0] r, input int t);
      if (t >= 0) begin
         for (int i = t - 1; i >= 0; i--) if (r[i]) return i;
      end
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      return -1;
   endfunction

   typedef struct {
      bit v;
      int g;
      int l;
      int a;
   } mstate_t;

   function automatic mstate_t step(input mstate_t s,
                                    input logic [N-1:0] r,
                                    input logic rdy);
      mstate_t    n;
      logic [N-1:0] rr;
      n   = s;
      n.a = -1;
      if (!s.v) begin
         if (r != '0) begin
            n.g = sel(r, s.l);
            n.v = 1'b1;
         end
      end else if (rdy) begin
         n.a = s.g;
         n.l = s.g;
         rr = r;
         rr[s.g] = 1'b0;
         n.g = sel(rr, s.g);
         n.v = (n.g >= 0);
      end
      return n;
   endfunction

   mstate_t m = '{v: 1'b0, g: -1, l: -1, a: -1};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{v: 1'b0, g: -1, l: -1, a: -1};
      else        m <= step(m, req, grant_ready);
   end

   int e_grant, e_idx, e_last;

   always @(negedge clk) begin
      e_grant = m.v ? (1 << m.g) : 0;
      e_idx   = m.v ? m.g : 0;
      e_last  = (m.l >= 0) ? (1 << m.l) : 0;
      chk("cyc_grant", int'(grant), e_grant);
      chk("cyc_idx", int'(grant_idx), e_idx);
      chk("cyc_valid", int'(grant_valid), int'(m.v));
      chk("cyc_last", int'(last_grant), e_last);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq[7] = '{8, 4, 2, 1, 16, 8, 4};

   initial begin
      chk("model_sel_below", sel(5'b11001, 2), 0);
      chk("model_sel_wrap", sel(5'b11000, 0), 4);
      chk("model_sel_reset", sel(5'b11111, -1), 4);

      rst_n = 1'b0;
      req = 5'b11111;
      grant_ready = 1'b0;
      repeat (2) tick();
      chk("rst_grant", int'(grant), 0);
      chk("rst_idx", int'(grant_idx), 0);
      chk("rst_valid", int'(grant_valid), 0);
      chk("rst_last", int'(last_grant), 0);

      rst_n = 1'b1;
      tick();
      chk("first_grant", int'(grant), 'h10);
      chk("first_idx", int'(grant_idx), 4);
      chk("first_valid", int'(grant_valid), 1);

      grant_ready = 1'b1;
      foreach (seq[k]) begin
         tick();
         chk("rot_grant", int'(grant), seq[k]);
         chk("rot_valid", int'(grant_valid), 1);
      end

      grant_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req = (k % 2 == 1) ? 5'b11111 : 5'b00110;
         tick();
         chk("stall_grant", int'(grant), 4);
         chk("stall_valid", int'(grant_valid), 1);
         chk("stall_last", int'(last_grant), 8);
      end

      req = 5'b00100;
      grant_ready = 1'b1;
      tick();
      chk("idle_valid", int'(grant_valid), 0);
      chk("idle_last", int'(last_grant), 4);
      req = 5'b11001;
      tick();
      chk("trunc_grant", int'(grant), 1);
      tick();
      chk("wrap_grant", int'(grant), 'h10);
      chk("wrap_last", int'(last_grant), 1);

      req = 5'b10000;
      tick();
      chk("drain_valid", int'(grant_valid), 0);
      req = 5'b00010;
      grant_ready = 1'b0;
      tick();
      chk("single_grant", int'(grant), 2);
      grant_ready = 1'b1;
      tick();
      chk("single_done_grant", int'(grant), 0);
      chk("single_done_valid", int'(grant_valid), 0);
      chk("single_done_last", int'(last_grant), 2);

      req = 5'b00100;
      grant_ready = 1'b0;
      tick();
      chk("pre_rst_grant", int'(grant), 4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_grant", int'(grant), 0);
      chk("async_valid", int'(grant_valid), 0);
      chk("async_last", int'(last_grant), 0);
      req = 5'b00011;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_grant", int'(grant), 2);
      chk("post_rst_idx", int'(grant_idx), 1);

      for (int c = 0; c < 3000; c++) begin
         grant_ready = ($urandom_range(2) != 0);
         for (int i = 0; i < N; i++) begin
            if (!(req[i] && m.a != i)) req[i] = ($urandom_range(3) == 0);
         end
         if (c % 700 == 350) begin
            #2 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
